// File: rtl/branch_pred_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : branch_pred_pkg
//  Description : Shared encodings, the BTB entry layout and the direction
//                counter update used by the branch target predictor.
//  Revision    : 1.0 - initial release
// ============================================================================
package branch_pred_pkg;

    localparam logic [1:0] SNT = 2'b00;
    localparam logic [1:0] WNT = 2'b01;
    localparam logic [1:0] WT  = 2'b10;
    localparam logic [1:0] ST  = 2'b11;

    // Entry layout at the default geometry (XLEN=32, 16 entries).
    localparam int BTB_DEF_XLEN  = 32;
    localparam int BTB_DEF_TAG_W = 26;

    typedef struct packed {
        logic                     valid;
        logic [BTB_DEF_TAG_W-1:0] tag;
        logic [BTB_DEF_XLEN-1:0]  target;
        logic [1:0]               cnt;
    } btb_entry_t;

    function automatic logic [1:0] cnt_update(input logic [1:0] cnt, input logic taken);
        logic [1:0] nxt;
        nxt = cnt;
        if (taken && cnt != ST) begin
            nxt = cnt + 2'd1;
        end else if (!taken && cnt != SNT) begin
            nxt = cnt - 2'd1;
        end
        return nxt;
    endfunction

endpackage
`default_nettype wire

// File: rtl/btb_entry_array.sv
`default_nettype none
// ============================================================================
//  Module      : btb_entry_array
//  Description : Direct-mapped BTB storage: two async read ports, one sync
//                write port and a whole-array valid clear.
//  Revision    : 1.0 - initial release
// ============================================================================
module btb_entry_array
    import branch_pred_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter int ENTRIES = 16,
    parameter int IDX_W   = $clog2(ENTRIES),
    parameter int TAG_W   = XLEN - IDX_W - 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_clear,
    input  logic [IDX_W-1:0] i_rd0_idx,
    output logic             o_rd0_valid,
    output logic [TAG_W-1:0] o_rd0_tag,
    output logic [XLEN-1:0]  o_rd0_target,
    output logic [1:0]       o_rd0_cnt,
    input  logic [IDX_W-1:0] i_rd1_idx,
    output logic             o_rd1_valid,
    output logic [TAG_W-1:0] o_rd1_tag,
    output logic [XLEN-1:0]  o_rd1_target,
    output logic [1:0]       o_rd1_cnt,
    input  logic             i_wr_en,
    input  logic [IDX_W-1:0] i_wr_idx,
    input  logic             i_wr_valid,
    input  logic [TAG_W-1:0] i_wr_tag,
    input  logic [XLEN-1:0]  i_wr_target,
    input  logic [1:0]       i_wr_cnt
);

    typedef struct packed {
        logic             valid;
        logic [TAG_W-1:0] tag;
        logic [XLEN-1:0]  target;
        logic [1:0]       cnt;
    } entry_t;

    entry_t r_mem [ENTRIES];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < ENTRIES; i++) begin
                r_mem[i] <= '{valid: 1'b0, tag: '0, target: '0, cnt: WNT};
            end
        end else if (i_clear) begin
            // Clear wins over a same-cycle training write.
            for (int i = 0; i < ENTRIES; i++) begin
                r_mem[i].valid <= 1'b0;
            end
        end else if (i_wr_en) begin
            r_mem[i_wr_idx] <= '{valid: i_wr_valid, tag: i_wr_tag,
                                 target: i_wr_target, cnt: i_wr_cnt};
        end
    end

    assign o_rd0_valid  = r_mem[i_rd0_idx].valid;
    assign o_rd0_tag    = r_mem[i_rd0_idx].tag;
    assign o_rd0_target = r_mem[i_rd0_idx].target;
    assign o_rd0_cnt    = r_mem[i_rd0_idx].cnt;

    assign o_rd1_valid  = r_mem[i_rd1_idx].valid;
    assign o_rd1_tag    = r_mem[i_rd1_idx].tag;
    assign o_rd1_target = r_mem[i_rd1_idx].target;
    assign o_rd1_cnt    = r_mem[i_rd1_idx].cnt;

endmodule
`default_nettype wire

// File: rtl/branch_target_predictor.sv
`default_nettype none
// ============================================================================
//  Module      : branch_target_predictor
//  Description : BTB-based next-PC predictor with execute-side resolution,
//                training, registered redirect and mispredict statistics.
//  Revision    : 1.0 - initial release
// ============================================================================
module branch_target_predictor
    import branch_pred_pkg::*;
#(
    parameter int          XLEN    = 32,
    parameter int          ENTRIES = 16,
    parameter int unsigned PC_ADJ  = 4,
    parameter int          CNT_W   = 16
) (
    input  logic             clk_pi,
    input  logic             rst_n_pi,
    input  logic             flush_pi,
    input  logic             lookup_valid_pi,
    input  logic [XLEN-1:0]  lookup_pc_pi,
    output logic             pred_valid_po,
    output logic             pred_taken_po,
    output logic [XLEN-1:0]  pred_target_po,
    input  logic             resolve_valid_pi,
    input  logic [XLEN-1:0]  resolve_pc_pi,
    input  logic             isBranch_or_jump_pi,
    input  logic             branchCondTrue_pi,
    input  logic [XLEN-1:0]  branchOffset_pi,
    input  logic             resolve_pred_taken_pi,
    input  logic [XLEN-1:0]  resolve_pred_target_pi,
    output logic             isTakenBranch_po,
    output logic             redirect_po,
    output logic [XLEN-1:0]  redirect_pc_po,
    output logic [CNT_W-1:0] mispredict_count_po
);

    localparam int              IDX_W      = $clog2(ENTRIES);
    localparam int              TAG_W      = XLEN - IDX_W - 2;
    localparam logic [XLEN-1:0] c_pc_adj   = XLEN'(PC_ADJ);
    localparam logic [XLEN-1:0] c_inst_len = XLEN'(4);

    logic [IDX_W-1:0] w_lk_idx, w_rs_idx;
    logic [TAG_W-1:0] w_lk_tag, w_rs_tag;
    logic             w_lk_valid, w_rs_valid;
    logic [TAG_W-1:0] w_lk_etag, w_rs_etag;
    logic [XLEN-1:0]  w_lk_etarget, w_rs_etarget;
    logic [1:0]       w_lk_cnt, w_rs_cnt;
    logic             w_lk_hit, w_rs_hit, w_lk_taken;

    logic             w_wr_en, w_wr_valid;
    logic [TAG_W-1:0] w_wr_tag;
    logic [XLEN-1:0]  w_wr_target;
    logic [1:0]       w_wr_cnt;

    logic [XLEN-1:0]  w_actual_target, w_next_pc;
    logic             w_taken, w_mispredict;
    logic             w_unused;

    logic             r_pred_valid, r_pred_taken;
    logic [XLEN-1:0]  r_pred_target;
    logic             r_redirect;
    logic [XLEN-1:0]  r_redirect_pc;
    logic [CNT_W-1:0] r_mispredict_count;

    assign w_lk_idx = lookup_pc_pi[IDX_W+1:2];
    assign w_lk_tag = lookup_pc_pi[XLEN-1:IDX_W+2];
    assign w_rs_idx = resolve_pc_pi[IDX_W+1:2];
    assign w_rs_tag = resolve_pc_pi[XLEN-1:IDX_W+2];
    assign w_unused = ^{lookup_pc_pi[1:0], resolve_pc_pi[1:0]};

    btb_entry_array #(
        .XLEN    (XLEN),
        .ENTRIES (ENTRIES),
        .IDX_W   (IDX_W),
        .TAG_W   (TAG_W)
    ) u_btb (
        .clk          (clk_pi),
        .rst_n        (rst_n_pi),
        .i_clear      (flush_pi),
        .i_rd0_idx    (w_lk_idx),
        .o_rd0_valid  (w_lk_valid),
        .o_rd0_tag    (w_lk_etag),
        .o_rd0_target (w_lk_etarget),
        .o_rd0_cnt    (w_lk_cnt),
        .i_rd1_idx    (w_rs_idx),
        .o_rd1_valid  (w_rs_valid),
        .o_rd1_tag    (w_rs_etag),
        .o_rd1_target (w_rs_etarget),
        .o_rd1_cnt    (w_rs_cnt),
        .i_wr_en      (w_wr_en),
        .i_wr_idx     (w_rs_idx),
        .i_wr_valid   (w_wr_valid),
        .i_wr_tag     (w_wr_tag),
        .i_wr_target  (w_wr_target),
        .i_wr_cnt     (w_wr_cnt)
    );

    assign w_lk_hit   = w_lk_valid && (w_lk_etag == w_lk_tag);
    assign w_rs_hit   = w_rs_valid && (w_rs_etag == w_rs_tag);
    assign w_lk_taken = w_lk_hit && w_lk_cnt[1];

    // Fetch side: async read of pre-update contents gives read-before-write.
    always_ff @(posedge clk_pi or negedge rst_n_pi) begin
        if (!rst_n_pi) begin
            r_pred_valid  <= 1'b0;
            r_pred_taken  <= 1'b0;
            r_pred_target <= '0;
        end else if (flush_pi) begin
            r_pred_valid  <= 1'b0;
        end else if (lookup_valid_pi) begin
            r_pred_valid  <= 1'b1;
            r_pred_taken  <= w_lk_taken;
            r_pred_target <= w_lk_taken ? w_lk_etarget : lookup_pc_pi + c_inst_len;
        end else begin
            r_pred_valid  <= 1'b0;
        end
    end

    assign w_taken         = resolve_valid_pi && isBranch_or_jump_pi && branchCondTrue_pi;
    assign w_actual_target = resolve_pc_pi + branchOffset_pi + c_pc_adj;
    assign w_next_pc       = w_taken ? w_actual_target : resolve_pc_pi + c_inst_len;
    assign w_mispredict    = resolve_valid_pi &&
                             ((resolve_pred_taken_pi != w_taken) ||
                              (w_taken && (resolve_pred_target_pi != w_actual_target)));

    always_ff @(posedge clk_pi or negedge rst_n_pi) begin
        if (!rst_n_pi) begin
            r_redirect         <= 1'b0;
            r_redirect_pc      <= '0;
            r_mispredict_count <= '0;
        end else begin
            r_redirect    <= w_mispredict;
            r_redirect_pc <= w_next_pc;
            if (w_mispredict && (r_mispredict_count != '1)) begin
                r_mispredict_count <= r_mispredict_count + 1'b1;
            end
        end
    end

    always_comb begin
        w_wr_en     = 1'b0;
        w_wr_valid  = 1'b0;
        w_wr_tag    = w_rs_tag;
        w_wr_target = w_rs_etarget;
        w_wr_cnt    = w_rs_cnt;
        if (resolve_valid_pi) begin
            if (isBranch_or_jump_pi) begin
                if (w_rs_hit) begin
                    w_wr_en    = 1'b1;
                    w_wr_valid = 1'b1;
                    w_wr_cnt   = cnt_update(w_rs_cnt, w_taken);
                    if (w_taken) begin
                        w_wr_target = w_actual_target;
                    end
                end else if (w_taken) begin
                    w_wr_en     = 1'b1;
                    w_wr_valid  = 1'b1;
                    w_wr_target = w_actual_target;
                    w_wr_cnt    = WT;
                end
            end else if (w_rs_hit) begin
                // A non-branch matching an entry means the entry is a stale alias.
                w_wr_en    = 1'b1;
                w_wr_valid = 1'b0;
            end
        end
    end

    assign pred_valid_po       = r_pred_valid;
    assign pred_taken_po       = r_pred_taken;
    assign pred_target_po      = r_pred_target;
    assign isTakenBranch_po    = w_taken;
    assign redirect_po         = r_redirect;
    assign redirect_pc_po      = r_redirect_pc;
    assign mispredict_count_po = r_mispredict_count;

endmodule
`default_nettype wire

// File: tb/tb_branch_target_predictor.sv
`default_nettype none
// ============================================================================
//  Module      : tb_branch_target_predictor
//  Description : Directed self-checking bench for branch_target_predictor.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_branch_target_predictor;

    localparam int XLEN  = 32;
    localparam int CNT_W = 3;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             flush;
    logic             lookup_valid;
    logic [XLEN-1:0]  lookup_pc;
    logic             pred_valid, pred_taken;
    logic [XLEN-1:0]  pred_target;
    logic             resolve_valid;
    logic [XLEN-1:0]  resolve_pc;
    logic             is_br, cond_true;
    logic [XLEN-1:0]  offset;
    logic             rs_pred_taken;
    logic [XLEN-1:0]  rs_pred_target;
    logic             is_taken;
    logic             redirect;
    logic [XLEN-1:0]  redirect_pc;
    logic [CNT_W-1:0] mp_count;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    branch_target_predictor #(
        .XLEN    (XLEN),
        .ENTRIES (16),
        .PC_ADJ  (4),
        .CNT_W   (CNT_W)
    ) dut (
        .clk_pi                 (clk),
        .rst_n_pi               (rst_n),
        .flush_pi               (flush),
        .lookup_valid_pi        (lookup_valid),
        .lookup_pc_pi           (lookup_pc),
        .pred_valid_po          (pred_valid),
        .pred_taken_po          (pred_taken),
        .pred_target_po         (pred_target),
        .resolve_valid_pi       (resolve_valid),
        .resolve_pc_pi          (resolve_pc),
        .isBranch_or_jump_pi    (is_br),
        .branchCondTrue_pi      (cond_true),
        .branchOffset_pi        (offset),
        .resolve_pred_taken_pi  (rs_pred_taken),
        .resolve_pred_target_pi (rs_pred_target),
        .isTakenBranch_po       (is_taken),
        .redirect_po            (redirect),
        .redirect_pc_po         (redirect_pc),
        .mispredict_count_po    (mp_count)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        flush          = 1'b0;
        lookup_valid   = 1'b0;
        resolve_valid  = 1'b0;
        is_br          = 1'b0;
        cond_true      = 1'b0;
        offset         = '0;
        rs_pred_taken  = 1'b0;
        rs_pred_target = '0;
    endtask

    task automatic lookup(input logic [XLEN-1:0] pc);
        lookup_valid = 1'b1;
        lookup_pc    = pc;
    endtask

    task automatic resolve(input logic [XLEN-1:0] pc, input logic br, input logic cnd,
                           input logic [XLEN-1:0] off, input logic pt,
                           input logic [XLEN-1:0] ptgt);
        resolve_valid  = 1'b1;
        resolve_pc     = pc;
        is_br          = br;
        cond_true      = cnd;
        offset         = off;
        rs_pred_taken  = pt;
        rs_pred_target = ptgt;
    endtask

    task automatic do_lookup(input string tag, input logic [XLEN-1:0] pc,
                             input logic exp_taken, input logic [XLEN-1:0] exp_tgt);
        idle();
        lookup(pc);
        tick();
        chk({tag, ".valid"}, {31'd0, pred_valid}, 32'd1);
        chk({tag, ".taken"}, {31'd0, pred_taken}, {31'd0, exp_taken});
        chk({tag, ".target"}, pred_target, exp_tgt);
    endtask

    task automatic do_resolve(input string tag, input logic [XLEN-1:0] pc, input logic br,
                              input logic cnd, input logic [XLEN-1:0] off, input logic pt,
                              input logic [XLEN-1:0] ptgt, input logic exp_redir,
                              input logic [XLEN-1:0] exp_pc, input int exp_cnt);
        idle();
        resolve(pc, br, cnd, off, pt, ptgt);
        tick();
        chk({tag, ".redirect"}, {31'd0, redirect}, {31'd0, exp_redir});
        chk({tag, ".redirect_pc"}, redirect_pc, exp_pc);
        chk({tag, ".count"}, {29'd0, mp_count}, exp_cnt);
    endtask

    initial begin
        idle();
        lookup_pc  = '0;
        resolve_pc = '0;
        rst_n      = 1'b0;
        tick();
        tick();
        chk("rst.pred_valid", {31'd0, pred_valid}, 32'd0);
        chk("rst.pred_taken", {31'd0, pred_taken}, 32'd0);
        chk("rst.pred_target", pred_target, 32'd0);
        chk("rst.redirect", {31'd0, redirect}, 32'd0);
        chk("rst.redirect_pc", redirect_pc, 32'd0);
        chk("rst.count", {29'd0, mp_count}, 32'd0);
        rst_n = 1'b1;
        tick();

        do_lookup("cold", 32'h100, 1'b0, 32'h104);
        idle();
        tick();
        chk("cold.idle_valid", {31'd0, pred_valid}, 32'd0);
        chk("cold.idle_hold", pred_target, 32'h104);

        // First taken resolve allocates the entry with counter 10.
        idle();
        resolve(32'h100, 1'b1, 1'b1, 32'h20, 1'b0, 32'h104);
        #1;
        chk("alloc.isTaken", {31'd0, is_taken}, 32'd1);
        tick();
        chk("alloc.redirect", {31'd0, redirect}, 32'd1);
        chk("alloc.redirect_pc", redirect_pc, 32'h124);
        chk("alloc.count", {29'd0, mp_count}, 32'd1);
        idle();
        tick();
        chk("alloc.pulse_end", {31'd0, redirect}, 32'd0);
        do_lookup("hit", 32'h100, 1'b1, 32'h124);

        // Counter 10 -> 01 -> 00.
        do_resolve("nt1", 32'h100, 1'b1, 1'b0, 32'h20, 1'b1, 32'h124, 1'b1, 32'h104, 2);
        do_resolve("nt2", 32'h100, 1'b1, 1'b0, 32'h20, 1'b0, 32'h104, 1'b0, 32'h104, 2);
        do_lookup("after_nt", 32'h100, 1'b0, 32'h104);

        // Counter 00 -> 11 over three taken resolves, then held at 11.
        for (int i = 0; i < 3; i++) begin
            do_resolve("up", 32'h100, 1'b1, 1'b1, 32'h20, 1'b1, 32'h124, 1'b0, 32'h124, 2);
        end
        do_lookup("strong", 32'h100, 1'b1, 32'h124);
        do_resolve("sat", 32'h100, 1'b1, 1'b1, 32'h20, 1'b1, 32'h124, 1'b0, 32'h124, 2);
        do_resolve("down", 32'h100, 1'b1, 1'b0, 32'h20, 1'b1, 32'h124, 1'b1, 32'h104, 3);
        do_lookup("still_taken", 32'h100, 1'b1, 32'h124);

        // 0x140 aliases 0x100 at index 0 and evicts it.
        do_resolve("alias", 32'h140, 1'b1, 1'b1, 32'h10, 1'b0, 32'h0, 1'b1, 32'h154, 4);
        do_lookup("evicted", 32'h100, 1'b0, 32'h104);
        do_lookup("alias_hit", 32'h140, 1'b1, 32'h154);

        idle();
        resolve(32'h140, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        #1;
        chk("nonbr.isTaken", {31'd0, is_taken}, 32'd0);
        tick();
        chk("nonbr.redirect", {31'd0, redirect}, 32'd0);
        chk("nonbr.redirect_pc", redirect_pc, 32'h144);
        do_lookup("invalidated", 32'h140, 1'b0, 32'h144);

        // Wrap-around targets, back-to-back mispredicts, wrong-target mispredict.
        do_resolve("wrap1", 32'hFFFF_FFF8, 1'b1, 1'b1, 32'h0, 1'b0, 32'h0, 1'b1, 32'hFFFF_FFFC, 5);
        do_resolve("wrap2", 32'hFFFF_FFFC, 1'b1, 1'b1, 32'h0, 1'b0, 32'h0, 1'b1, 32'h0, 6);
        do_resolve("badtgt", 32'hFFFF_FFFC, 1'b1, 1'b1, 32'h0, 1'b1, 32'h4, 1'b1, 32'h0, 7);

        // Same-cycle lookup and allocate: lookup sees the old miss; count saturates at 7.
        idle();
        resolve(32'h200, 1'b1, 1'b1, 32'h40, 1'b0, 32'h0);
        lookup(32'h200);
        tick();
        chk("rbw.taken", {31'd0, pred_taken}, 32'd0);
        chk("rbw.target", pred_target, 32'h204);
        chk("rbw.redirect_pc", redirect_pc, 32'h244);
        chk("rbw.count_sat", {29'd0, mp_count}, 32'd7);
        do_lookup("rbw_after", 32'h200, 1'b1, 32'h244);

        // Flush beats the same-cycle allocate and lookup but not the redirect.
        idle();
        flush = 1'b1;
        resolve(32'h300, 1'b1, 1'b1, 32'h0, 1'b0, 32'h0);
        lookup(32'h300);
        tick();
        chk("flush.pred_valid", {31'd0, pred_valid}, 32'd0);
        chk("flush.redirect", {31'd0, redirect}, 32'd1);
        chk("flush.redirect_pc", redirect_pc, 32'h304);
        chk("flush.count", {29'd0, mp_count}, 32'd7);
        do_lookup("flush_new", 32'h300, 1'b0, 32'h304);
        do_lookup("flush_old", 32'h200, 1'b0, 32'h204);

        // Reset in the middle of a redirect pulse.
        do_resolve("pre_rst", 32'h100, 1'b1, 1'b1, 32'h0, 1'b0, 32'h0, 1'b1, 32'h104, 7);
        rst_n = 1'b0;
        #1;
        chk("midrst.redirect", {31'd0, redirect}, 32'd0);
        chk("midrst.redirect_pc", redirect_pc, 32'h0);
        chk("midrst.count", {29'd0, mp_count}, 32'd0);
        idle();
        tick();
        rst_n = 1'b1;
        tick();
        chk("postrst.redirect", {31'd0, redirect}, 32'd0);
        do_lookup("postrst", 32'h100, 1'b0, 32'h104);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
